// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: shared states, widths and the first-mismatch helper
package truth_table_checker_pkg;
  localparam int VEC_COUNT = 16;
  localparam int IDX_W = 4;
  localparam int SETTLE_W = 8;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;
  function automatic logic [IDX_W-1:0] first_set(input logic [VEC_COUNT-1:0] v);
    first_set = '0;
    for (int i = VEC_COUNT - 1; i >= 0; i--) if (v[i]) first_set = IDX_W'(i);
  endfunction
endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: control, result and block-under-test signals of the checker
interface truth_table_checker_if;
  import truth_table_checker_pkg::*;
  logic start;
  logic [VEC_COUNT-1:0] expected;
  logic [VEC_COUNT-1:0] captured;
  logic a, b, c, d, f;
  logic busy, done, pass;
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
  logic fail_valid;
  logic [IDX_W-1:0] fail_idx;
`endif
  modport master (output start, expected, f, input a, b, c, d, busy, done, pass, captured
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
    , fail_valid, fail_idx
`endif
  );
  modport slave (input start, expected, f, output a, b, c, d, busy, done, pass, captured
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
    , fail_valid, fail_idx
`endif
  );
endinterface

// File: rtl/truth_table_checker_settle_counter.sv
// tt_settle_counter: loadable down-counter flagging terminal count at zero
module tt_settle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = (cnt == '0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !tc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps 16 input vectors, captures f and compares to a golden table
// Optional macro TRUTH_TABLE_CHECKER_FAIL_IDX_EN adds fail_valid/fail_idx reporting.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic reset_n,
  truth_table_checker_if.slave bus
);
  // DRIVE holds SETTLE_CYCLES-1 cycles; with a single settle cycle it is skipped entirely
  localparam logic [SETTLE_W-1:0] LOAD = SETTLE_W'(SETTLE_CYCLES > 1 ? SETTLE_CYCLES - 2 : 0);
  localparam state_t FIRST = (SETTLE_CYCLES > 1) ? DRIVE : SAMPLE;
  state_t state;
  logic [IDX_W-1:0] idx, vec;
  logic [VEC_COUNT-1:0] golden;
  logic tc;
  tt_settle_counter #(.W(SETTLE_W)) u_settle (
    .clk(clk),
    .reset_n(reset_n),
    .load(state != DRIVE),
    .dec(state == DRIVE),
    .load_val(LOAD),
    .tc(tc)
  );
  assign {bus.a, bus.b, bus.c, bus.d} = vec;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      vec <= '0;
      golden <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.captured <= '0;
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
      bus.fail_valid <= 1'b0;
      bus.fail_idx <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          golden <= bus.expected;
          bus.captured <= '0;
          bus.pass <= 1'b0;
          idx <= '0;
          vec <= '0;
          bus.busy <= 1'b1;
          state <= FIRST;
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
          bus.fail_valid <= 1'b0;
          bus.fail_idx <= '0;
`endif
        end
        DRIVE: if (tc) state <= SAMPLE;
        SAMPLE: begin
          bus.captured[idx] <= bus.f;
          if (idx == IDX_W'(VEC_COUNT - 1)) begin
            vec <= '0;
            state <= FINISH;
          end else begin
            idx <= idx + 1'b1;
            vec <= idx + 1'b1;
            state <= FIRST;
          end
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.pass <= (bus.captured == golden);
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
          bus.fail_valid <= |(bus.captured ^ golden);
          bus.fail_idx <= first_set(bus.captured ^ golden);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed scoreboard bench for the truth table checker
module tb_truth_table_checker;
  typedef struct packed {
    logic pass;
    logic [15:0] cap;
    logic fv;
    logic [3:0] fi;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sbq[$];
  truth_table_checker_if bus ();
  truth_table_checker_if bus2 ();
  truth_table_checker #(.SETTLE_CYCLES(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  assign bus.f = bus.a ^ bus.b ^ bus.c ^ bus.d;
  assign bus2.f = 1'b1;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] golden);
    exp_t e;
    logic [15:0] diff;
    for (int i = 0; i < 16; i++) e.cap[i] = ^(4'(i));
    diff = e.cap ^ golden;
    e.pass = (diff == 16'h0);
    e.fv = |diff;
    e.fi = 4'h0;
    for (int i = 15; i >= 0; i--) if (diff[i]) e.fi = 4'(i);
    return e;
  endfunction
  function automatic logic [31:0] vec_of(input logic a, input logic b, input logic c, input logic d);
    return {28'd0, a, b, c, d};
  endfunction
  task automatic sweep(input logic [15:0] exp_tt, input int restart_at, input int change_at);
    int lat;
    int extra;
    exp_t e;
    sbq.push_back(model(exp_tt));
    bus.expected = exp_tt;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    chk("busy_rise", 32'(bus.busy), 32'd1);
    while (!bus.done && lat < 100) begin
      if (lat < 32) chk("vector", vec_of(bus.a, bus.b, bus.c, bus.d), 32'(lat / 2));
      if (lat < 33) chk("busy", 32'(bus.busy), 32'd1);
      bus.start = (lat == restart_at);
      if (lat == change_at) bus.expected = ~exp_tt;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", 32'(lat), 32'd33);
    if (bus.done && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pass", 32'(bus.pass), 32'(e.pass));
      chk("captured", 32'(bus.captured), 32'(e.cap));
      chk("busy_fall", 32'(bus.busy), 32'd0);
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
      chk("fail_valid", 32'(bus.fail_valid), 32'(e.fv));
      chk("fail_idx", 32'(bus.fail_idx), 32'(e.fi));
`endif
      extra = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (bus.done) extra++;
      end
      chk("single_done", 32'(extra), 32'd0);
      chk("hold_pass", 32'(bus.pass), 32'(e.pass));
      chk("hold_captured", 32'(bus.captured), 32'(e.cap));
      chk("idle_vector", vec_of(bus.a, bus.b, bus.c, bus.d), 32'd0);
    end
  endtask
  initial begin
    int lat;
    int extra;
    bus.start = 1'b0;
    bus.expected = 16'h0;
    bus2.start = 1'b0;
    bus2.expected = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_captured", 32'(bus.captured), 32'd0);
    chk("rst_vector", vec_of(bus.a, bus.b, bus.c, bus.d), 32'd0);
`ifdef TRUTH_TABLE_CHECKER_FAIL_IDX_EN
    chk("rst_fail_valid", 32'(bus.fail_valid), 32'd0);
    chk("rst_fail_idx", 32'(bus.fail_idx), 32'd0);
`endif
    reset_n = 1'b1;
    sweep(16'h6996, -1, -1);
    sweep(16'h6997, -1, -1);
    sweep(16'h6996 ^ 16'h0100, -1, -1);
    sweep(16'h6996, 10, 5);
    bus.expected = 16'h6996;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_pass", 32'(bus.pass), 32'd0);
    chk("abort_captured", 32'(bus.captured), 32'd0);
    chk("abort_vector", vec_of(bus.a, bus.b, bus.c, bus.d), 32'd0);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    reset_n = 1'b1;
    sweep(16'h6996, -1, -1);
    bus2.expected = 16'hFFFF;
    bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    lat = 0;
    while (!bus2.done && lat < 100) begin
      if (lat < 16) chk("fast_vector", vec_of(bus2.a, bus2.b, bus2.c, bus2.d), 32'(lat));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("fast_latency", 32'(lat), 32'd17);
    chk("fast_pass", 32'(bus2.pass), 32'd1);
    chk("fast_captured", 32'(bus2.captured), 32'hFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
